// File: rtl/usrt_pkg.sv
// rtl/usrt_pkg.sv - shared serial framing constants, rx state encoding and parity helper
package usrt_pkg;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = DATA_W + 3;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_DATA      = 3'd1,
    RX_PARITY    = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  // Expected parity bit for the byte; modes other than odd fall back to even.
  function automatic logic par_bit(input logic [1:0] mode, input logic [DATA_W-1:0] data);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/rxdeframe.sv
// rtl/rxdeframe.sv - serial frame receiver: start/data/parity/stop strip with error flags
module rxdeframe #(
  parameter int DATA_W = 8
) (
  input  logic              i_Pclk,
  input  logic              i_Rst,
  input  logic              i_BitEn,
  input  logic              i_Rx,
  input  logic [1:0]        i_Parity,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Valid,
  output logic              o_ParErr,
  output logic              o_FrmErr,
  output logic              o_Busy
);
  import usrt_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_t         state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              par_q;

  logic has_par;
  assign has_par = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);

  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      state    <= RX_IDLE;
      mode_q   <= PAR_NONE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      o_Data   <= '0;
      o_Valid  <= 1'b0;
      o_ParErr <= 1'b0;
      o_FrmErr <= 1'b0;
      o_Busy   <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      if (i_BitEn) begin
        case (state)
          RX_IDLE: begin
            if (!i_Rx) begin
              mode_q  <= i_Parity;
              shift_q <= '0;
              cnt_q   <= '0;
              o_Busy  <= 1'b1;
              state   <= RX_DATA;
            end
          end
          RX_DATA: begin
            // LSB arrives first, so shifting right leaves it in bit 0 after DATA_W bits.
            shift_q <= {i_Rx, shift_q[DATA_W-1:1]};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state <= has_par ? RX_PARITY : RX_STOP;
            end
          end
          RX_PARITY: begin
            par_q <= i_Rx;
            state <= RX_STOP;
          end
          RX_STOP: begin
            o_Data   <= shift_q;
            o_ParErr <= has_par && (par_q != par_bit(mode_q, shift_q));
            o_FrmErr <= ~i_Rx;
            o_Valid  <= 1'b1;
            if (i_Rx) begin
              state  <= RX_IDLE;
              o_Busy <= 1'b0;
            end else begin
              state <= RX_WAIT_IDLE;
            end
          end
          RX_WAIT_IDLE: begin
            // A broken stop bit leaves the line low; only a high sample re-arms start detection.
            if (i_Rx) begin
              state  <= RX_IDLE;
              o_Busy <= 1'b0;
            end
          end
          default: begin
            state  <= RX_IDLE;
            o_Busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rxdeframe.sv
// tb/tb_rxdeframe.sv - scoreboard bench for rxdeframe with directed and random frames
module tb_rxdeframe;

  logic       i_Pclk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_BitEn = 1'b0;
  logic       i_Rx = 1'b1;
  logic [1:0] i_Parity = 2'b00;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_ParErr;
  logic       o_FrmErr;
  logic       o_Busy;

  rxdeframe #(.DATA_W(8)) dut (
    .i_Pclk(i_Pclk), .i_Rst(i_Rst), .i_BitEn(i_BitEn), .i_Rx(i_Rx),
    .i_Parity(i_Parity), .o_Data(o_Data), .o_Valid(o_Valid),
    .o_ParErr(o_ParErr), .o_FrmErr(o_FrmErr), .o_Busy(o_Busy)
  );

  always #5 i_Pclk = ~i_Pclk;

  typedef struct {
    logic [7:0] data;
    logic       par_err;
    logic       frm_err;
  } exp_t;

  exp_t exp_q[$];
  int   valid_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge i_Pclk) cyc <= cyc + 1;

  // Monitor: every valid strobe must match the oldest outstanding expectation.
  always @(negedge i_Pclk) begin
    if (o_Valid) begin
      valid_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data=%h par=%0b frm=%0b, required no valid", o_Data, o_ParErr, o_FrmErr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_Data !== e.data || o_ParErr !== e.par_err || o_FrmErr !== e.frm_err) begin
          errors++;
          $display("FAIL frame: got data=%h par=%0b frm=%0b, required data=%h par=%0b frm=%0b",
                   o_Data, o_ParErr, o_FrmErr, e.data, e.par_err, e.frm_err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    i_Rx = b;
    i_BitEn = 1'b1;
    @(posedge i_Pclk);
    #1;
    i_BitEn = 1'b0;
    repeat (gap) begin
      @(posedge i_Pclk);
      #1;
    end
  endtask

  // Reference: parity mode comes from the start bit; even parity bit = odd count of ones.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] mode, input logic flip_par,
                            input logic stop, input int gap, input logic [1:0] mid_mode);
    exp_t e;
    logic has_par;
    logic pbit;
    has_par = (mode == 2'b01) || (mode == 2'b10);
    pbit = ($countones(data) % 2 == 1) ? 1'b1 : 1'b0;
    if (mode == 2'b10) pbit = ~pbit;
    e.data = data;
    e.par_err = has_par && flip_par;
    e.frm_err = ~stop;
    exp_q.push_back(e);
    i_Parity = mode;
    send_bit(1'b0, gap);
    check("busy_after_start", 32'(o_Busy), 32'd1);
    i_Parity = mid_mode;
    for (int i = 0; i < 8; i++) send_bit(data[i], gap);
    if (has_par) send_bit(pbit ^ flip_par, gap);
    send_bit(stop, gap);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge i_Pclk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge i_Pclk);
    #1;
    check("reset_outputs", {o_Data, o_Valid, o_ParErr, o_FrmErr, o_Busy}, 32'd0);
    i_Rst = 1'b0;
    send_bit(1'b1, 0);

    // 1: even parity, A5
    send_frame(8'hA5, 2'b01, 1'b0, 1'b1, 0, 2'b01);
    drain("t1_drain");
    check("t1_busy_idle", 32'(o_Busy), 32'd0);

    // 2: odd parity with wrong parity bit
    send_frame(8'h01, 2'b10, 1'b1, 1'b1, 1, 2'b10);
    drain("t2_drain");

    // 3: no parity, modes 00 and 11
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 0, 2'b00);
    drain("t3a_drain");
    send_frame(8'h3C, 2'b11, 1'b0, 1'b1, 2, 2'b11);
    drain("t3b_drain");

    // 4: stop bit low, line held low, then recovery
    send_frame(8'hFF, 2'b01, 1'b0, 1'b0, 0, 2'b01);
    repeat (3) send_bit(1'b0, 0);
    drain("t4_drain");
    check("t4_busy_wait", 32'(o_Busy), 32'd1);
    send_bit(1'b1, 0);
    check("t4_busy_released", 32'(o_Busy), 32'd0);
    send_frame(8'h12, 2'b01, 1'b0, 1'b1, 0, 2'b01);
    drain("t4_next_drain");

    // 5: reset after four data bits
    i_Parity = 2'b01;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    i_Rst = 1'b1;
    @(posedge i_Pclk);
    #1;
    i_Rst = 1'b0;
    check("t5_reset_outputs", {o_Data, o_Valid, o_ParErr, o_FrmErr, o_Busy}, 32'd0);
    repeat (4) send_bit(1'b1, 0);
    check("t5_no_valid", 32'(valid_cyc.size()), 32'd6);
    send_frame(8'h5A, 2'b01, 1'b0, 1'b1, 0, 2'b01);
    drain("t5_next_drain");

    // 6: back-to-back, bit enable every cycle, parity input changed mid-frame
    valid_cyc.delete();
    send_frame(8'h00, 2'b01, 1'b0, 1'b1, 0, 2'b10);
    send_frame(8'h81, 2'b01, 1'b0, 1'b1, 0, 2'b10);
    drain("t6_drain");
    check("t6_valid_count", 32'(valid_cyc.size()), 32'd2);
    if (valid_cyc.size() == 2) check("t6_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'd11);

    // Random frames
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic [1:0] m;
      logic fl;
      logic st;
      d  = 8'($urandom);
      m  = 2'($urandom);
      fl = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, m, fl, st, $urandom_range(0, 2), 2'($urandom));
      if (!st) send_bit(1'b1, 0);
      repeat ($urandom_range(0, 2)) send_bit(1'b1, 0);
    end
    drain("rand_drain");
    check("final_busy", 32'(o_Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
